serial_comparator: RTL
======================

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to compare x and y.
REQ-005 SHALL have port x, input, WIDTH, first operand.
REQ-006 SHALL have port y, input, WIDTH, second operand.
REQ-007 SHALL have port busy, output, 1, high while bits are being processed.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-009 SHALL have port o_gt, output, 1, result x > y.
REQ-010 SHALL have port o_eq, output, 1, result x == y.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 SHALL accept start only in IDLE: capture x and y into internal shift registers, clear the bit counter, set gt_acc=0 and eq_acc=1, then go to SHIFT.
REQ-013 SHALL in each SHIFT cycle process the shift-register LSBs (bit i, LSB-first):
- gt_acc <= (xi & ~yi) | ((xi ~^ yi) & gt_acc)
- eq_acc <= eq_acc & (xi ~^ yi)
- shift both registers right by one
- increment the counter.
REQ-014 SHALL stay in SHIFT for exactly WIDTH cycles, then go to DONE with o_gt/o_eq loaded from the final accumulator values.
REQ-015 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-016 SHALL give a latency, with start sampled high at cycle 0, of done=1 at cycle WIDTH+1.
REQ-017 SHALL hold busy=1 only in SHIFT.
REQ-018 SHALL ignore start in SHIFT and DONE; it is not queued.
REQ-019 SHALL hold o_gt/o_eq stable from DONE until the next accepted start completes.
REQ-020 SHALL never assert o_gt and o_eq together.
REQ-021 SHALL capture operands only at acceptance; x/y changes during SHIFT have no effect.
REQ-022 SHALL saturate the bit counter at WIDTH; it never wraps.

Reset
REQ-023 SHALL on rst=1, at any time including mid-SHIFT, immediately force:
- FSM to IDLE
- busy=0, done=0, o_gt=0, o_eq=0
- counter, shift registers and accumulators to 0.
REQ-024 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL, with SERIAL_CMP_SIGNED_EN defined, treat x and y as two's complement: on the final (MSB) bit, gt_acc <= (~xi & yi) | ((xi ~^ yi) & gt_acc).
REQ-026 SHALL, without SERIAL_CMP_SIGNED_EN, perform unsigned comparison on all bits per REQ-013; eq behaviour is identical in both builds.

Structure
REQ-027 SHALL place the FSM state typedef (IDLE/SHIFT/DONE) and the counter-width constant in shared package serial_cmp_pkg.
REQ-028 SHALL factor the per-bit update into sub-module lsb_compare_cell (inputs xi, yi, gt_in, eq_in, msb_signed; outputs gt_out, eq_out), instantiated once.

Verification (WIDTH=4)
REQ-029 SHALL verify: x=9, y=6, start at cycle 0 -> busy cycles 1-4; done=1, o_gt=1, o_eq=0 at cycle 5 only.
REQ-030 SHALL verify: x=5, y=5 -> o_gt=0, o_eq=1; x=0, y=15 -> o_gt=0, o_eq=0.
REQ-031 SHALL verify: x=8, y=1 -> o_gt=1 without the macro; o_gt=0 with SERIAL_CMP_SIGNED_EN (-8 < 1).
REQ-032 SHALL verify: start held high through a whole compare with x=3, y=2, then x/y changed to 0/7 at cycle 2 -> result o_gt=1; a second compare begins only in the first IDLE cycle after DONE.
REQ-033 SHALL verify: rst pulsed at cycle 2 of a compare -> all outputs 0 immediately and no done; a new start x=2, y=1 then yields o_gt=1 at cycle 5.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared types and constants for the serial comparator
//
// Purpose : FSM state encoding and bit-counter width shared by the
//           serial_comparator top and its test bench.
// Contents: state_e  - IDLE / SHIFT / DONE
//           CNT_W    - bit-counter width, wide enough to hold WIDTH up to 32
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter must reach WIDTH itself (it saturates there), so 32 needs 6 bits.
  localparam int CNT_W = 6;

endpackage

// File: rtl/lsb_compare_cell.sv
// rtl/lsb_compare_cell.sv - one-bit LSB-first magnitude/equality update
//
// Purpose : combinational step of the serial compare. A later (more
//           significant) bit overrides the running gt result unless the
//           two bits are equal, in which case the lower-bit verdict stands.
// Ports   : xi, yi       - current bit of each operand
//           gt_in, eq_in - accumulated result from the lower bits
//           msb_signed   - this is the sign bit of a two's-complement compare
//           gt_out       - updated "x > y" verdict
//           eq_out       - updated "x == y" verdict
module lsb_compare_cell (
  input  logic xi,
  input  logic yi,
  input  logic gt_in,
  input  logic eq_in,
  input  logic msb_signed,
  output logic gt_out,
  output logic eq_out
);

  logic same;
  logic bit_gt;

  assign same = xi ~^ yi;

  // A set sign bit means negative, so at the sign position the sense inverts.
  assign bit_gt = msb_signed ? (~xi & yi) : (xi & ~yi);

  assign gt_out = bit_gt | (same & gt_in);
  assign eq_out = eq_in & same;

endmodule

// File: rtl/serial_comparator.sv
// rtl/serial_comparator.sv - bit-serial x/y magnitude comparator
//
// Purpose : captures x and y on an accepted start, walks them LSB-first one
//           bit per clock, and reports x > y / x == y with a one-cycle done.
// Ports   : clk   - clock, rising edge
//           rst   - asynchronous active-high reset
//           start - compare request, honoured only in IDLE
//           x, y  - WIDTH-bit operands, sampled only at acceptance
//           busy  - high while bits are being processed
//           done  - one-cycle pulse when o_gt / o_eq are fresh
//           o_gt  - x > y
//           o_eq  - x == y
// Config  : define SERIAL_CMP_SIGNED_EN for a two's-complement compare;
//           the default build compares unsigned.
module serial_comparator #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             o_gt,
  output logic             o_eq
);

  import serial_cmp_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

  state_e             state_q;
  logic [WIDTH-1:0]   x_sh_q;
  logic [WIDTH-1:0]   y_sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               gt_acc_q;
  logic               eq_acc_q;
  logic               gt_acc_d;
  logic               eq_acc_d;
  logic               last_bit;
  logic               msb_signed;

  assign last_bit = (cnt_q == CNT_LAST);
  assign cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

`ifdef SERIAL_CMP_SIGNED_EN
  assign msb_signed = last_bit;
`else
  assign msb_signed = 1'b0;
`endif

  lsb_compare_cell u_cell (
    .xi         (x_sh_q[0]),
    .yi         (y_sh_q[0]),
    .gt_in      (gt_acc_q),
    .eq_in      (eq_acc_q),
    .msb_signed (msb_signed),
    .gt_out     (gt_acc_d),
    .eq_out     (eq_acc_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_sh_q   <= '0;
      y_sh_q   <= '0;
      cnt_q    <= '0;
      gt_acc_q <= 1'b0;
      eq_acc_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      o_gt     <= 1'b0;
      o_eq     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_sh_q   <= x;
            y_sh_q   <= y;
            cnt_q    <= '0;
            gt_acc_q <= 1'b0;
            eq_acc_q <= 1'b1;
            busy     <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          gt_acc_q <= gt_acc_d;
          eq_acc_q <= eq_acc_d;
          x_sh_q   <= x_sh_q >> 1;
          y_sh_q   <= y_sh_q >> 1;
          cnt_q    <= cnt_d;
          // Results are taken from the cell directly so the last bit's
          // update lands in o_gt/o_eq on the same edge that enters DONE.
          if (last_bit) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            o_gt    <= gt_acc_d;
            o_eq    <= eq_acc_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
